// File: rtl/dyn_mem_pkg.sv
// Shared types and sizing helpers for the bank-group demultiplexer.
package dyn_mem_pkg;

  localparam int unsigned MaxSelW = 8;

  // Bank-group select index as stored in the in-order select FIFO.
  typedef logic [MaxSelW-1:0] bkgp_idx_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dyn_mem_sel_fifo.sv
// In-order FIFO of bank-group selects for granted requests awaiting rvalid.
module dyn_mem_sel_fifo
  import dyn_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CntW  = cnt_width(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  bkgp_idx_t       push_idx_i,
  input  logic            pop_i,
  output bkgp_idx_t       head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = idx_width(DEPTH);

  bkgp_idx_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Count saturates naturally: pushes are ignored when full, pops when empty.
  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_idx_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dyn_mem_bkgp_demux.sv
// Routes one TCDM request port to NUM_BANK_GROUP bank groups and returns responses in order.
// Define DYN_MEM_BKGP_RSP_REG_EN to register tcdm_rdata_o/tcdm_rvalid_o (one extra cycle).
module dyn_mem_bkgp_demux
  import dyn_mem_pkg::*;
#(
  parameter int unsigned NUM_BANK_GROUP        = 2,
  parameter int unsigned BANK_GROUP_DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH            = 16,
  parameter int unsigned SEL_LSB               = 3,
  parameter int unsigned MAX_OUTSTANDING       = 4
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic [BANK_GROUP_DATA_WIDTH-1:0]                  tcdm_wdata_i,
  input  logic [ADDR_WIDTH-1:0]                             tcdm_addr_i,
  input  logic                                              tcdm_we_i,
  input  logic [BANK_GROUP_DATA_WIDTH/8-1:0]                tcdm_strb_i,
  input  logic                                              tcdm_req_i,
  output logic                                              tcdm_gnt_o,
  output logic [BANK_GROUP_DATA_WIDTH-1:0]                  tcdm_rdata_o,
  output logic                                              tcdm_rvalid_o,
  output logic [BANK_GROUP_DATA_WIDTH-1:0]                  bkgp_wdata_o [NUM_BANK_GROUP],
  output logic [ADDR_WIDTH-idx_width(NUM_BANK_GROUP)-1:0]   bkgp_addr_o  [NUM_BANK_GROUP],
  output logic [NUM_BANK_GROUP-1:0]                         bkgp_we_o,
  output logic [BANK_GROUP_DATA_WIDTH/8-1:0]                bkgp_strb_o  [NUM_BANK_GROUP],
  output logic [NUM_BANK_GROUP-1:0]                         bkgp_req_o,
  input  logic [NUM_BANK_GROUP-1:0]                         bkgp_gnt_i,
  input  logic [BANK_GROUP_DATA_WIDTH-1:0]                  bkgp_rdata_i [NUM_BANK_GROUP],
  input  logic [NUM_BANK_GROUP-1:0]                         bkgp_rvalid_i,
  output logic [cnt_width(MAX_OUTSTANDING)-1:0]             outstanding_o,
  output logic                                              rsp_err_o
);

  localparam int unsigned SelW  = idx_width(NUM_BANK_GROUP);
  localparam int unsigned DW    = BANK_GROUP_DATA_WIDTH;

  // Handshake: a request is taken in the cycle where bkgp_req_o[sel] and
  // bkgp_gnt_i[sel] are both high; each taken request owes exactly one rvalid,
  // returned by its group in grant order.
  logic [SelW-1:0]            sel;
  logic [ADDR_WIDTH-SelW-1:0] addr_strip;
  logic                       req_ok;
  logic                       fifo_full;
  logic                       fifo_empty;
  bkgp_idx_t                  head_idx;
  logic                       head_rvalid;
  logic [DW-1:0]              head_rdata;
  logic                       stray;
  logic                       pop;
  logic                       err_set;
  logic [DW-1:0]              rsp_data;
  logic                       rsp_err_q;

  assign sel = tcdm_addr_i[SEL_LSB +: SelW];

  if (SEL_LSB == 0) begin : g_strip_low
    assign addr_strip = tcdm_addr_i[ADDR_WIDTH-1:SelW];
  end else begin : g_strip_mid
    assign addr_strip = {tcdm_addr_i[ADDR_WIDTH-1:SEL_LSB+SelW], tcdm_addr_i[SEL_LSB-1:0]};
  end

  // full comes from the registered count only, so rvalid never reaches gnt.
  assign req_ok = tcdm_req_i & ~fifo_full & ~rst_i;

  always_comb begin
    for (int g = 0; g < int'(NUM_BANK_GROUP); g++) begin
      bkgp_wdata_o[g] = tcdm_wdata_i;
      bkgp_addr_o[g]  = addr_strip;
      bkgp_we_o[g]    = tcdm_we_i;
      bkgp_strb_o[g]  = tcdm_strb_i;
      bkgp_req_o[g]   = req_ok & (sel == SelW'(g));
    end
  end

  assign tcdm_gnt_o = |(bkgp_req_o & bkgp_gnt_i);

  dyn_mem_sel_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_sel_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (tcdm_gnt_o),
    .push_idx_i (bkgp_idx_t'(sel)),
    .pop_i      (pop),
    .head_o     (head_idx),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (outstanding_o)
  );

  // Any rvalid from a group other than the head is out of order and dropped.
  always_comb begin
    head_rvalid = 1'b0;
    head_rdata  = '0;
    stray       = 1'b0;
    for (int g = 0; g < int'(NUM_BANK_GROUP); g++) begin
      if (head_idx == bkgp_idx_t'(g)) begin
        head_rvalid = bkgp_rvalid_i[g];
        head_rdata  = bkgp_rdata_i[g];
      end else if (bkgp_rvalid_i[g]) begin
        stray = 1'b1;
      end
    end
  end

  assign pop      = head_rvalid & ~fifo_empty;
  assign err_set  = ((|bkgp_rvalid_i) & fifo_empty) | stray;
  assign rsp_data = pop ? head_rdata : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rsp_err_q <= 1'b0;
    else if (err_set) rsp_err_q <= 1'b1;
  end
  assign rsp_err_o = rsp_err_q;

`ifdef DYN_MEM_BKGP_RSP_REG_EN
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= pop;
      rsp_data_q  <= rsp_data;
    end
  end
  assign tcdm_rvalid_o = rsp_valid_q;
  assign tcdm_rdata_o  = rsp_data_q;
`else
  assign tcdm_rvalid_o = pop;
  assign tcdm_rdata_o  = rsp_data;
`endif

endmodule
